// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: arbitrates the single shared btb index port between fetch
// lookups and buffered execute-stage target updates. Updates wait in a small
// FIFO. Fetch has priority, but a starve counter forces an update through
// after STARVE_LIMIT cycles of denial.
// Optional build macro: BTB_UPD_COALESCE_EN (merge an update into the newest
// queued entry when the pc matches).
module btb_update_ctrl #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   input  logic [15:0] fetch_pc,
   output logic        fetch_ready,
   output logic        pred_valid,
   output logic        pred_hit,
   output logic [15:0] pred_target,
   input  logic        upd_valid,
   input  logic [15:0] upd_pc,
   input  logic [15:0] upd_target,
   output logic        upd_ready,
   output logic [15:0] btb_addr,
   output logic [15:0] btb_wdata,
   output logic        btb_we,
   input  logic [15:0] btb_branch_address,
   input  logic        btb_miss
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {StNormal, StForce} state_e;

   state_e        state_q;
   logic [SW-1:0] starve_q;
   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic [15:0]   pc_mem  [DEPTH];
   logic [15:0]   tgt_mem [DEPTH];
   logic          pred_valid_q;
   logic          pred_hit_q;
   logic [15:0]   pred_target_q;

   logic          fifo_full;
   logic          fifo_nempty;
   logic          grant_fetch;
   logic          grant_upd;
   logic          push;
   logic          coalesce;
   logic [PW-1:0] newest;

   assign fifo_full   = (count_q == CW'(DEPTH));
   assign fifo_nempty = (count_q != '0);
   assign newest      = tail_q - 1'b1;

   // Port arbitration: fetch wins in NORMAL, FORCE hands the port to the FIFO head.
   always_comb begin
      grant_fetch = 1'b0;
      grant_upd   = 1'b0;
      case (state_q)
         StNormal: begin
            grant_fetch = fetch_valid;
            grant_upd   = !fetch_valid && fifo_nempty;
         end
         StForce: grant_upd = 1'b1;
      endcase
   end

`ifdef BTB_UPD_COALESCE_EN
   // Merge into the newest entry unless it is the head leaving this cycle.
   assign coalesce = upd_valid && fifo_nempty && (upd_pc == pc_mem[newest]) &&
                     !((count_q == CW'(1)) && grant_upd);
`else
   assign coalesce = 1'b0;
`endif

   // Full blocks enqueue even when the head is popped in the same cycle.
   assign push        = upd_valid && !fifo_full && !coalesce;
   assign upd_ready   = coalesce || !fifo_full;
   assign fetch_ready = grant_fetch;

   // Drive the btb port: head entry on an update grant, otherwise fetch_pc read.
   always_comb begin
      btb_we    = 1'b0;
      btb_addr  = fetch_pc;
      btb_wdata = '0;
      if (grant_upd) begin
         btb_we    = 1'b1;
         btb_addr  = pc_mem[head_q];
         btb_wdata = tgt_mem[head_q];
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push)      tail_q <= tail_q + 1'b1;
         if (grant_upd) head_q <= head_q + 1'b1;
         case ({push, grant_upd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[tail_q]  <= upd_pc;
         tgt_mem[tail_q] <= upd_target;
      end else if (coalesce) begin
         tgt_mem[newest] <= upd_target;
      end
   end

   // Arbitration FSM, starve counter and registered prediction outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StNormal;
         starve_q      <= '0;
         pred_valid_q  <= 1'b0;
         pred_hit_q    <= 1'b0;
         pred_target_q <= '0;
      end else begin
         pred_valid_q  <= grant_fetch;
         pred_hit_q    <= grant_fetch && !btb_miss;
         pred_target_q <= (grant_fetch && !btb_miss) ? btb_branch_address : '0;
         case (state_q)
            StNormal: begin
               if (!fifo_nempty || grant_upd) begin
                  starve_q <= '0;
               end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                  state_q  <= StForce;
                  starve_q <= '0;
               end else begin
                  starve_q <= starve_q + 1'b1;
               end
            end
            StForce: begin
               state_q  <= StNormal;
               starve_q <= '0;
            end
         endcase
      end
   end

   assign pred_valid  = pred_valid_q;
   assign pred_hit    = pred_hit_q;
   assign pred_target = pred_target_q;

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Sequences the shared single-index port of the 4-way branch target buffer (btb) between fetch-stage lookups and execute-stage target updates.
- The btb uses one address bus for both read and write, so a lookup and an update cannot occur in the same cycle.
- Resolved-branch updates are buffered in a small FIFO. Each cycle the controller grants the btb port to either a lookup or an update.
- Sits between fetch, the execute/branch-resolve stage and the btb instance.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be denied before an update is forced

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- fetch_valid  input  1  fetch requests a btb lookup this cycle
- fetch_pc  input  16  lookup address
- fetch_ready  output  1  lookup granted this cycle
- pred_valid  output  1  registered prediction result valid
- pred_hit  output  1  registered: btb hit for the accepted lookup
- pred_target  output  16  registered predicted target (0 when !pred_hit)
- upd_valid  input  1  execute stage offers an update
- upd_pc  input  16  branch pc to install
- upd_target  input  16  resolved branch target
- upd_ready  output  1  update accepted this cycle
- btb_addr  output  16  to btb target_addr
- btb_wdata  output  16  to btb new_branch_address
- btb_we  output  1  to btb we
- btb_branch_address  input  16  from btb branch_address
- btb_miss  input  1  from btb miss

Behaviour:
- FIFO: DEPTH entries of {pc, target}, with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH.
  - upd_ready = (count != DEPTH). No enqueue when full, even if a dequeue happens in the same cycle.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- FSM (registered), states NORMAL and FORCE.
  - NORMAL: grant fetch if fetch_valid. Otherwise grant update if count>0.
  - FORCE: grant update unconditionally (count>0 is guaranteed); fetch_ready=0. Always returns to NORMAL next cycle.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments each NORMAL cycle with count>0 and no update granted.
  - Clears on any update grant or when count==0.
  - When it would reach STARVE_LIMIT, the next state is FORCE and the counter clears.
- Update grant:
  - btb_addr=head.pc, btb_wdata=head.target, btb_we=1; pop head.
- Fetch grant:
  - btb_addr=fetch_pc, btb_we=0, fetch_ready=1.
  - Next cycle: pred_valid=1, pred_hit=!btb_miss, pred_target=btb_branch_address if hit else 0.
  - Latency is 1 cycle.
- No grant:
  - btb_we=0, btb_addr holds fetch_pc, btb_wdata=0. pred_valid=0 next cycle.
- fetch_ready is combinational from fetch_valid, state and count. The fetch stage must hold fetch_pc while fetch_ready=0.
- Reset, at any point including mid-operation:
  - Clears count, pointers, starve counter and FSM (NORMAL).
  - pred_valid=0, pred_hit=0, pred_target=0, btb_we=0.
  - Pending updates are discarded. btb contents are not touched.
- A btb_we cycle never asserts fetch_ready. An update pushed in cycle N is eligible for grant no earlier than N+1.

Optional Feature:
- Macro BTB_UPD_COALESCE_EN.
- Defined: if upd_valid, count>0, and upd_pc equals the pc of the newest (tail-1) entry, then:
  - that entry's target is overwritten;
  - count is unchanged;
  - upd_ready=1 even when full.
  - Exception: if that entry is the head and is being dequeued this cycle, a normal enqueue is done instead.
- Undefined: every accepted update allocates a new entry.

Test Plan:
- Reset, then fetch_valid=1, pc=0x0010, btb miss -> fetch_ready=1; next cycle pred_valid=1, pred_hit=0, pred_target=0x0000.
- fetch idle, push {0x0010,0x0200} -> next cycle btb_we=1, btb_addr=0x0010, btb_wdata=0x0200. Then a lookup of 0x0010 -> pred_hit=1, pred_target=0x0200.
- fetch_valid held high, one update queued, STARVE_LIMIT=8 -> update granted on cycle 9 after the enqueue, fetch_ready=0 that cycle only.
- Push 4 updates with fetch saturating -> upd_ready=0 at count=4. A 5th push is held until a force-dequeue, and FIFO order is preserved on btb writes.
- With 3 entries queued, assert rst for 1 cycle -> count=0, btb_we never asserts afterward without a new push, pred_valid=0.
- BTB_UPD_COALESCE_EN: push {0x0020,0x0300} then {0x0020,0x0340} -> count=1, single btb write with wdata=0x0340. Without the macro: count=2, two writes.
